// File: rtl/bli201v32i_pkg.sv
// Shared BLI201V32I core definitions: fetch-sequencer state encoding,
// the NOP instruction word and small helpers used by the sequencer.
package bli201v32i_pkg;

  localparam logic [2:0] SEQ_FETCH      = 3'd0;
  localparam logic [2:0] SEQ_FETCH_WAIT = 3'd1;
  localparam logic [2:0] SEQ_EXEC       = 3'd2;
  localparam logic [2:0] SEQ_DATA       = 3'd3;
  localparam logic [2:0] SEQ_DATA_WAIT  = 3'd4;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  localparam mem_req_t MEM_REQ_IDLE = '{req: 1'b0, we: 1'b0, wstrb: 4'd0,
                                        addr: 32'd0, wdata: 32'd0};

  function automatic logic [31:0] inc32(input logic [31:0] v);
    return v + 32'd1;
  endfunction

endpackage

// File: rtl/register_rst_en.sv
// Generic register with synchronous active-high reset and load enable.
module register_rst_en #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= RST_VAL;
    end else if (en_i) begin
      q_q <= d_i;
    end else begin
      q_q <= q_q;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/imem_fetch_sequencer.sv
// Shares one single-port memory between instruction fetch and load/store,
// holding each fetched instruction until it retires exactly once.
module imem_fetch_sequencer #(
  parameter logic [31:0] NOP_INST         = 32'h0000_0013,
  parameter bit          RESET_INST_VALID = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dbg_i_halt,
  input  logic [31:0] ifu_i_iaddr,
  output logic        seq_o_ifu_halt,
  output logic [31:0] seq_o_inst,
  output logic        seq_o_inst_valid,
  input  logic        lsu_i_req,
  input  logic        lsu_i_we,
  input  logic [3:0]  lsu_i_wstrb,
  input  logic [31:0] lsu_i_addr,
  input  logic [31:0] lsu_i_wdata,
  output logic [31:0] lsu_o_rdata,
  output logic        lsu_o_done,
  output logic        mem_o_req,
  output logic        mem_o_we,
  output logic [3:0]  mem_o_wstrb,
  output logic [31:0] mem_o_addr,
  output logic [31:0] mem_o_wdata,
  input  logic [31:0] mem_i_rdata,
  input  logic        mem_i_rvalid,
  output logic [31:0] seq_o_retire_cnt
);

  import bli201v32i_pkg::*;

  logic [2:0]  state_q, state_d;
  logic        inst_valid_q, inst_valid_d;
  logic        inst_load, rdata_load, retire, done;
  mem_req_t    mreq;
  logic [31:0] inst_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SEQ_FETCH;
      inst_valid_q <= RESET_INST_VALID;
    end else begin
      state_q      <= state_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  // Responses arriving outside the two wait states are ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SEQ_FETCH:      state_d = dbg_i_halt   ? SEQ_FETCH : SEQ_FETCH_WAIT;
      SEQ_FETCH_WAIT: state_d = mem_i_rvalid ? SEQ_EXEC  : SEQ_FETCH_WAIT;
      SEQ_EXEC:       state_d = lsu_i_req    ? SEQ_DATA  : SEQ_FETCH;
      SEQ_DATA:       state_d = SEQ_DATA_WAIT;
      SEQ_DATA_WAIT:  state_d = mem_i_rvalid ? SEQ_FETCH : SEQ_DATA_WAIT;
      default:        state_d = SEQ_FETCH;
    endcase
  end

  always_comb begin
    mreq       = MEM_REQ_IDLE;
    inst_load  = 1'b0;
    rdata_load = 1'b0;
    retire     = 1'b0;
    done       = 1'b0;
    case (state_q)
      SEQ_FETCH: begin
        if (!dbg_i_halt && !rst) begin
          mreq.req  = 1'b1;
          mreq.addr = ifu_i_iaddr;
        end else begin
          mreq = MEM_REQ_IDLE;
        end
      end
      SEQ_FETCH_WAIT: inst_load = mem_i_rvalid;
      SEQ_EXEC:       retire    = ~lsu_i_req;
      SEQ_DATA: begin
        mreq.req   = 1'b1;
        mreq.we    = lsu_i_we;
        mreq.wstrb = lsu_i_wstrb;
        mreq.addr  = lsu_i_addr;
        mreq.wdata = lsu_i_wdata;
      end
      SEQ_DATA_WAIT: begin
        done       = mem_i_rvalid;
        retire     = mem_i_rvalid;
        rdata_load = mem_i_rvalid & ~lsu_i_we;
      end
      default: mreq = MEM_REQ_IDLE;
    endcase
    if (inst_load) begin
      inst_valid_d = 1'b1;
    end else if (retire) begin
      inst_valid_d = 1'b0;
    end else begin
      inst_valid_d = inst_valid_q;
    end
  end

  register_rst_en #(.WIDTH(32), .RST_VAL(32'd0)) u_inst_reg (
    .clk_i(clk), .rst_i(rst), .en_i(inst_load), .d_i(mem_i_rdata), .q_o(inst_q)
  );

  register_rst_en #(.WIDTH(32), .RST_VAL(32'd0)) u_rdata_reg (
    .clk_i(clk), .rst_i(rst), .en_i(rdata_load), .d_i(mem_i_rdata), .q_o(lsu_o_rdata)
  );

  register_rst_en #(.WIDTH(32), .RST_VAL(32'd0)) u_cnt_reg (
    .clk_i(clk), .rst_i(rst), .en_i(retire), .d_i(inc32(seq_o_retire_cnt)),
    .q_o(seq_o_retire_cnt)
  );

  assign seq_o_ifu_halt   = ~retire;
  assign seq_o_inst_valid = inst_valid_q;
  assign seq_o_inst       = inst_valid_q ? inst_q : NOP_INST;
  assign lsu_o_done       = done;
  assign mem_o_req        = mreq.req;
  assign mem_o_we         = mreq.we;
  assign mem_o_wstrb      = mreq.wstrb;
  assign mem_o_addr       = mreq.addr;
  assign mem_o_wdata      = mreq.wdata;

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Bench for imem_fetch_sequencer: instruction-level timing model, a latency
// memory driven by observed requests, and literal pins on key scenarios.
module tb_imem_fetch_sequencer;

  typedef struct {
    logic [31:0] pc, inst;
    bit          mem, we;
    logic [3:0]  wstrb;
    logic [31:0] addr, wdata, rdata;
    int          lat;
  } ins_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst, dbg_halt, ifu_halt, inst_valid, lsu_req, lsu_we, lsu_done;
  logic        mem_req, mem_we, mem_rvalid;
  logic [3:0]  lsu_wstrb, mem_wstrb;
  logic [31:0] iaddr, inst, lsu_addr, lsu_wdata, lsu_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata, retire_cnt;

  imem_fetch_sequencer dut (
    .clk(clk), .rst(rst), .dbg_i_halt(dbg_halt), .ifu_i_iaddr(iaddr),
    .seq_o_ifu_halt(ifu_halt), .seq_o_inst(inst), .seq_o_inst_valid(inst_valid),
    .lsu_i_req(lsu_req), .lsu_i_we(lsu_we), .lsu_i_wstrb(lsu_wstrb),
    .lsu_i_addr(lsu_addr), .lsu_i_wdata(lsu_wdata), .lsu_o_rdata(lsu_rdata),
    .lsu_o_done(lsu_done), .mem_o_req(mem_req), .mem_o_we(mem_we),
    .mem_o_wstrb(mem_wstrb), .mem_o_addr(mem_addr), .mem_o_wdata(mem_wdata),
    .mem_i_rdata(mem_rdata), .mem_i_rvalid(mem_rvalid),
    .seq_o_retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  ins_t        prog [9];
  rsp_t        mq [$];
  int          req_cyc [$];
  logic [31:0] req_addr [$];
  logic [3:0]  req_wstrb [$];
  logic        req_we [$];
  int          n_pass = 0, n_total = 0;
  int          cyc = 0, cur = 0, s = 0, n_ret = 0, ret_cyc = 0;
  bit          idle = 1'b1, model_en = 1'b0, inject_stale = 1'b0;
  logic [31:0] cnt_exp = 32'd0, rdata_exp = 32'd0, ret_inst = 32'd0;
  logic        ret_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
  endtask

  // Instruction-level timing: fetch at offset 0, retire at L+1 (or 2L+2 with data).
  task automatic model_step();
    ins_t p;
    int   off, l, endo;
    bit   ex_req, ex_fetch, ex_valid, ex_fin;
    p = prog[cur];
    l = p.lat;
    if (idle && !rst && !dbg_halt) begin
      idle = 1'b0;
      s    = cyc;
    end
    off      = idle ? -1 : cyc - s;
    endo     = p.mem ? 2 * l + 2 : l + 1;
    ex_fetch = !idle && off == 0;
    ex_req   = ex_fetch || (!idle && p.mem && off == l + 2);
    ex_valid = !idle && off >= l + 1 && off <= endo;
    ex_fin   = !idle && off == endo;
    chk("mem_req", mem_req, ex_req);
    chk("mem_addr", mem_addr, !ex_req ? 32'd0 : ex_fetch ? p.pc : p.addr);
    chk("mem_we", mem_we, ex_req && !ex_fetch && p.we);
    chk("mem_wstrb", mem_wstrb, (ex_req && !ex_fetch) ? p.wstrb : 4'd0);
    chk("mem_wdata", mem_wdata, (ex_req && !ex_fetch) ? p.wdata : 32'd0);
    chk("ifu_halt", ifu_halt, !ex_fin);
    chk("lsu_done", lsu_done, ex_fin && p.mem);
    chk("inst_valid", inst_valid, ex_valid);
    chk("inst", inst, ex_valid ? p.inst : 32'h0000_0013);
    chk("lsu_rdata", lsu_rdata, rdata_exp);
    chk("retire_cnt", retire_cnt, cnt_exp);
    if (mem_req === 1'b1) begin
      req_cyc.push_back(cyc);
      req_addr.push_back(mem_addr);
      req_wstrb.push_back(mem_wstrb);
      req_we.push_back(mem_we);
      mq.push_back('{due: cyc + l,
                     data: mem_we ? 32'hBAD0_BAD0 : (ex_fetch ? p.inst : p.rdata)});
    end
    if (ifu_halt === 1'b0) begin
      ret_cyc  = cyc;
      ret_inst = inst;
      ret_done = lsu_done;
    end
    if (ex_fin) begin
      cnt_exp = cnt_exp + 32'd1;
      if (p.mem && !p.we) rdata_exp = p.rdata;
      n_ret++;
      idle = 1'b1;
    end
    if (rst) begin
      cnt_exp   = 32'd0;
      rdata_exp = 32'd0;
      idle      = 1'b1;
      mq.delete();
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (model_en) model_step();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
    if (inject_stale) begin
      mem_rvalid   = 1'b1;
      mem_rdata    = 32'h5757_5757;
      inject_stale = 1'b0;
    end else if (mq.size() > 0 && mq[0].due == cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mq[0].data;
      void'(mq.pop_front());
    end
  endtask

  task automatic drive_instr(input int k);
    cur       = k;
    iaddr     = prog[k].pc;
    lsu_req   = prog[k].mem;
    lsu_we    = prog[k].we;
    lsu_wstrb = prog[k].wstrb;
    lsu_addr  = prog[k].addr;
    lsu_wdata = prog[k].wdata;
  endtask

  task automatic run_instr(input int k, input bit raise_dbg, output int t0, output int nq0);
    int nr0, lim;
    drive_instr(k);
    t0  = cyc;
    nq0 = req_cyc.size();
    nr0 = n_ret;
    lim = 0;
    while (n_ret == nr0 && lim < 50) begin
      tick();
      lim++;
      if (raise_dbg && lim == 1) dbg_halt = 1'b1;
    end
    if (n_ret == nr0) chk("retire_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int t0, nq0, nq;
    prog[0] = '{32'h00, 32'h0050_0093, 0, 0, 4'h0, 32'h0,   32'h0,    32'h0,         1};
    prog[1] = '{32'h04, 32'h1000_2083, 1, 0, 4'hF, 32'h100, 32'h77,   32'hDEAD_BEEF, 3};
    prog[2] = '{32'h08, 32'h0011_1023, 1, 1, 4'h3, 32'h104, 32'h1234, 32'h0,         2};
    prog[3] = '{32'h0C, 32'h0010_0113, 0, 0, 4'h0, 32'h0,   32'h0,    32'h0,         2};
    prog[4] = '{32'h10, 32'h0020_0193, 0, 0, 4'h0, 32'h0,   32'h0,    32'h0,         1};
    prog[5] = '{32'h14, 32'h1080_2203, 1, 0, 4'hF, 32'h108, 32'h0,    32'hCAFE_F00D, 3};
    prog[6] = '{32'h14, 32'h0030_0293, 0, 0, 4'h0, 32'h0,   32'h0,    32'h0,         2};
    prog[7] = '{32'h18, 32'h10C0_2303, 1, 0, 4'hF, 32'h10C, 32'h0,    32'h0BAD_F00D, 1};
    prog[8] = '{32'h1C, 32'h0040_0393, 0, 0, 4'h0, 32'h0,   32'h0,    32'h0,         1};
    rst = 1'b1; dbg_halt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    drive_instr(0);
    tick();
    model_en = 1'b1;
    tick();
    rst = 1'b0;

    // addi with L=1: fetch this cycle, retire two cycles later
    run_instr(0, 1'b0, t0, nq0);
    chk("t1_fetch_cycle", req_cyc[nq0], t0);
    chk("t1_retire_offset", ret_cyc - t0, 32'd2);
    chk("t1_inst", ret_inst, 32'h0050_0093);
    chk("t1_cnt", retire_cnt, 32'd1);

    // load with L=3: done and halt release in the 9th cycle
    run_instr(1, 1'b0, t0, nq0);
    chk("ld_data_addr", req_addr[nq0 + 1], 32'h100);
    chk("ld_done_offset", ret_cyc - t0, 32'd8);
    chk("ld_done_with_halt", ret_done, 1'b1);
    chk("ld_rdata", lsu_rdata, 32'hDEAD_BEEF);

    // store keeps previous load data
    run_instr(2, 1'b0, t0, nq0);
    chk("st_wstrb", req_wstrb[nq0 + 1], 4'b0011);
    chk("st_we", req_we[nq0 + 1], 1'b1);
    chk("st_rdata_kept", lsu_rdata, 32'hDEAD_BEEF);
    chk("st_cnt", retire_cnt, 32'd3);

    // debug halt raised in FETCH_WAIT: instruction retires, then no fetch
    run_instr(3, 1'b1, t0, nq0);
    chk("dbg_retired", retire_cnt, 32'd4);
    nq = req_cyc.size();
    repeat (4) tick();
    chk("dbg_no_req", req_cyc.size() - nq, 32'd0);
    dbg_halt = 1'b0;
    run_instr(4, 1'b0, t0, nq0);
    chk("dbg_resume_fetch", req_cyc[nq0], t0);

    // reset in DATA_WAIT followed by a stale response
    drive_instr(5);
    repeat (6) tick();
    rst = 1'b1;
    inject_stale = 1'b1;
    tick();
    rst = 1'b0;
    dbg_halt = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_cnt", retire_cnt, 32'd0);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_done", lsu_done, 1'b0);
    chk("rst_halt", ifu_halt, 1'b1);
    chk("rst_rdata", lsu_rdata, 32'd0);
    tick();
    dbg_halt = 1'b0;
    run_instr(6, 1'b0, t0, nq0);
    chk("post_rst_fetch", req_cyc[nq0], t0);
    chk("post_rst_cnt", retire_cnt, 32'd1);

    // load with L=1: 2L+3 = 5 cycles
    run_instr(7, 1'b0, t0, nq0);
    chk("ld1_done_offset", ret_cyc - t0, 32'd4);
    chk("ld1_rdata", lsu_rdata, 32'h0BAD_F00D);

    // counter wrap
    force dut.u_cnt_reg.q_q = 32'hFFFF_FFFF;
    cnt_exp = 32'hFFFF_FFFF;
    #1;
    release dut.u_cnt_reg.q_q;
    run_instr(8, 1'b0, t0, nq0);
    chk("cnt_wrap", retire_cnt, 32'd0);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
